max_pool_scheduler: RTL and testbench
=====================================

# max_pool_scheduler

Sequencer that walks an IN_H × IN_W feature map in non-overlapping 2×2 windows and drives the 64-channel max-pooling datapath. For each window it issues the window origin coordinates and a `valid_in` strobe to the datapath, then collects the datapath's `valid_out` returns. It generates output-buffer write enables and addresses from those returns and signals completion once every issued window has returned. It sits between the layer controller (`start`/`done`) and the pooling datapath plus its output buffer.

## Interface
- IN_H, default 8, input map height; must be even and ≥ 2.
- IN_W, default 8, input map width; must be even and ≥ 2.
- LAT, default 2, datapath latency from `valid_in` to `valid_out` in cycles; must be ≥ 1.
- Derived: N_WIN = (IN_H/2)·(IN_W/2); RW = $clog2(IN_H); CW = $clog2(IN_W); AW = $clog2(N_WIN), with a minimum of 1.
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, begin one map pass; sampled only in IDLE.
- out_ready, in, 1, downstream can absorb new results; gates issue.
- pool_valid_out, in, 1, datapath result strobe.
- pool_valid, out, 1, drives datapath `valid_in`.
- win_row, out, RW, window origin row (always even).
- win_col, out, CW, window origin column (always even).
- wr_en, out, 1, output-buffer write strobe.
- wr_addr, out, AW, output-buffer address (raster order).
- busy, out, 1, high in ISSUE and DRAIN.
- done, out, 1, one-cycle completion pulse.
- err, out, 1, sticky flag: a return arrived while no window was outstanding.

## Operation
- States:
  - IDLE: `start` → ISSUE; clears the window counters, issue count, return count and `err`.
  - ISSUE: issues windows; after the last issue → DRAIN.
  - DRAIN: waits for returns; when ret_cnt == N_WIN → DONE.
  - DONE: one cycle; `done` = 1 → IDLE.
- Issue behaviour:
  - pool_valid = (state == ISSUE) & out_ready. This is combinational from registered state.
  - On each issue, the column advances by 2.
  - When col = IN_W−2, the column wraps to 0 and the row advances by 2.
  - The issue at (IN_H−2, IN_W−2) is the last; the state moves to DRAIN on that edge.
  - When out_ready = 0 in ISSUE, no issue happens and the coordinates hold.
- Returns:
  - wr_en = pool_valid_out & busy.
  - wr_addr = ret_cnt (registered, AW bits).
  - ret_cnt increments on each wr_en.
  - Results return in issue order, so wr_addr = (row/2)·(IN_W/2) + col/2 of the matching window.
- Downstream contract: when out_ready falls, the sink must still absorb up to LAT in-flight results. The datapath has no stall.
- Error detection:
  - pool_valid_out while outstanding (issued − returned) == 0, or while in IDLE, sets `err`.
  - The stray pulse is not written: wr_en is suppressed and ret_cnt does not move.
  - `err` clears only on reset or on the next accepted `start`.
- `start` while busy is ignored.
- A simultaneous issue and return in the same cycle is normal; both counters update.

## Timing
- Reset values:
  - state = IDLE.
  - win_row = win_col = 0.
  - wr_addr = ret_cnt = issue_cnt = 0.
  - pool_valid = wr_en = busy = done = err = 0.
- Assertion mid-pass aborts immediately, with no `done`.
- start sampled at edge t:
  - From t+1: ISSUE and busy = 1.
  - First pool_valid in cycle t+1 if out_ready, carrying coordinates (0,0).
- Steady state with out_ready held high: one window per cycle and no bubbles.
- The datapath returns each result exactly LAT cycles after its issue. The scheduler does not depend on LAT except through the drain wait.
- done pulses in the cycle after the edge at which ret_cnt reaches N_WIN. busy falls in that same cycle.
- Minimum pass length with no stalls: 1 + N_WIN + LAT + 1 cycles from start to done.

## Structure
- Package pool_pkg holds:
  - the state enum (IDLE, ISSUE, DRAIN, DONE);
  - the default IN_H/IN_W/LAT localparams;
  - the derived-width functions.
- Sub-module pool_win_counter: row/col generator with enable, clear and a `last` flag. It is instantiated once.
- FSM, issue/return counters and error logic live in max_pool_scheduler.
- Elaboration-time assertions check IN_H/IN_W even and LAT ≥ 1.

## Test plan
- 8×8, LAT = 2, out_ready = 1, start at cycle 0:
  - pool_valid high in cycles 1–16, coordinates (0,0),(0,2)…(6,6).
  - wr_en in cycles 3–18, wr_addr 0…15.
  - done in cycle 19 only.
- Same setup, out_ready = 0 in cycles 5–7:
  - No issues in those cycles and coordinates hold at (0,8→wrap)-correct values.
  - 16 issues total; done in cycle 22.
- A pool_valid_out pulse in IDLE → err = 1 with no wr_en. The next start → err = 0.
- rst_n low in cycle 10 of a pass: all outputs at reset values asynchronously and no done. A subsequent start runs a full, correct pass.
- start re-pulsed in cycles 4 and 12 of a pass: ignored, and the pass completes with exactly 16 writes.
- 2×2 map, LAT = 1: one issue in cycle 1, wr_en/wr_addr = 0 in cycle 2, done in cycle 3.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types, default geometry and width helpers for the max-pool scheduler.
package pool_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } pool_state_e;

  localparam int unsigned DefInH = 8;
  localparam int unsigned DefInW = 8;
  localparam int unsigned DefLat = 2;

  function automatic int unsigned n_win(input int unsigned h, input int unsigned w);
    return (h / 2) * (w / 2);
  endfunction

  function automatic int unsigned coord_w(input int unsigned d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

  function automatic int unsigned addr_w(input int unsigned h, input int unsigned w);
    return (n_win(h, w) > 1) ? $clog2(n_win(h, w)) : 1;
  endfunction

endpackage

// File: rtl/max_pool_scheduler_if.sv
// Control/datapath/output-buffer signal bundle around the max-pool scheduler.
interface max_pool_scheduler_if
  import pool_pkg::*;
#(
  parameter int unsigned RW = coord_w(DefInH),
  parameter int unsigned CW = coord_w(DefInW),
  parameter int unsigned AW = addr_w(DefInH, DefInW)
);
  logic          start;
  logic          out_ready;
  logic          pool_valid_out;
  logic          pool_valid;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    input  start, out_ready, pool_valid_out,
    output pool_valid, win_row, win_col, wr_en, wr_addr, busy, done, err
  );

  modport slave (
    output start, out_ready, pool_valid_out,
    input  pool_valid, win_row, win_col, wr_en, wr_addr, busy, done, err
  );
endinterface

// File: rtl/pool_win_counter.sv
// Raster-order 2x2 window origin generator; last flags the final window.
module pool_win_counter #(
  parameter int unsigned IN_H = 8,
  parameter int unsigned IN_W = 8,
  parameter int unsigned RW   = 3,
  parameter int unsigned CW   = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);
  localparam logic [RW-1:0] RowLast = RW'(IN_H - 2);
  localparam logic [CW-1:0] ColLast = CW'(IN_W - 2);

  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;

  assign last = (row_q == RowLast) && (col_q == ColLast);
  assign row  = row_q;
  assign col  = col_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else if (clr) begin
      row_q <= '0;
      col_q <= '0;
    end else if (en) begin
      if (col_q == ColLast) begin
        col_q <= '0;
        row_q <= last ? '0 : row_q + RW'(2);
      end else begin
        col_q <= col_q + CW'(2);
      end
    end
  end

endmodule

// File: rtl/max_pool_scheduler.sv
// Issues 2x2 pooling windows, tracks returns into the output buffer and flags stray returns.
module max_pool_scheduler
  import pool_pkg::*;
#(
  parameter int unsigned IN_H = DefInH,
  parameter int unsigned IN_W = DefInW,
  parameter int unsigned LAT  = DefLat
) (
  input logic                  clk,
  input logic                  rst_n,
  max_pool_scheduler_if.master bus
);
  localparam int unsigned RW   = coord_w(IN_H);
  localparam int unsigned CW   = coord_w(IN_W);
  localparam int unsigned AW   = addr_w(IN_H, IN_W);
  localparam int unsigned CntW = AW + 1;
  localparam logic [CntW-1:0] NWinC = CntW'(n_win(IN_H, IN_W));

  if ((IN_H % 2) != 0 || IN_H < 2) begin : g_bad_h
    $error("IN_H must be even and >= 2");
  end
  if ((IN_W % 2) != 0 || IN_W < 2) begin : g_bad_w
    $error("IN_W must be even and >= 2");
  end
  if (LAT < 1) begin : g_bad_lat
    $error("LAT must be >= 1");
  end

  pool_state_e     state_q, state_d;
  logic [CntW-1:0] issue_cnt_q, issue_cnt_d;
  logic [CntW-1:0] ret_cnt_q, ret_cnt_d;
  logic [CntW-1:0] outstanding;
  logic            err_q, err_d;
  logic            start_acc, issue, stray, wr, busy, last;

  assign start_acc   = (state_q == StIdle) && bus.start;
  assign issue       = (state_q == StIssue) && bus.out_ready;
  assign busy        = (state_q == StIssue) || (state_q == StDrain);
  assign outstanding = issue_cnt_q - ret_cnt_q;
  // A return with nothing in flight is never written, only flagged.
  assign stray       = bus.pool_valid_out && ((state_q == StIdle) || (outstanding == '0));
  assign wr          = bus.pool_valid_out && busy && !stray;

  pool_win_counter #(
    .IN_H(IN_H),
    .IN_W(IN_W),
    .RW  (RW),
    .CW  (CW)
  ) u_win_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (issue),
    .clr  (start_acc),
    .row  (bus.win_row),
    .col  (bus.win_col),
    .last (last)
  );

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    err_d       = err_q;
    if (issue) issue_cnt_d = issue_cnt_q + CntW'(1);
    if (wr)    ret_cnt_d   = ret_cnt_q + CntW'(1);
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d     = StIssue;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
          err_d       = 1'b0;
        end
      end
      StIssue: if (issue && last) state_d = StDrain;
      StDrain: if (ret_cnt_d == NWinC) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (stray) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      err_q       <= err_d;
    end
  end

  assign bus.pool_valid = issue;
  assign bus.wr_en      = wr;
  assign bus.wr_addr    = ret_cnt_q[AW-1:0];
  assign bus.busy       = busy;
  assign bus.done       = (state_q == StDone);
  assign bus.err        = err_q;

endmodule

// File: tb/tb_max_pool_scheduler.sv
// Scoreboard bench: passes queue expected issues/writes/done, a negedge monitor checks them.
module tb_max_pool_scheduler;
  import pool_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  max_pool_scheduler_if #(.RW(3), .CW(3), .AW(4)) bus1 ();
  max_pool_scheduler_if #(.RW(1), .CW(1), .AW(1)) bus2 ();

  max_pool_scheduler #(.IN_H(8), .IN_W(8), .LAT(2)) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  max_pool_scheduler #(.IN_H(2), .IN_W(2), .LAT(1)) dut2 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus2)
  );

  // Datapath models: fixed-latency delay of pool_valid, plus a stray-pulse injector.
  logic [1:0] pipe1;
  logic       pipe2;
  logic       inject = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe1 <= '0;
      pipe2 <= 1'b0;
    end else begin
      pipe1 <= {pipe1[0], bus1.pool_valid};
      pipe2 <= bus2.pool_valid;
    end
  end
  assign bus1.pool_valid_out = pipe1[1] | inject;
  assign bus2.pool_valid_out = pipe2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int t0 = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {int cyc; int row; int col;} iss_t;
  typedef struct {int cyc; int addr;} wr_t;
  iss_t iss1_q[$], iss2_q[$];
  wr_t  wr1_q[$], wr2_q[$];
  int   done1_q[$], done2_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    int   rel;
    iss_t ie;
    wr_t  we;
    int   de;
    rel = cyc - t0 + 1;
    if (rst_n) begin
      if (bus1.pool_valid) begin
        if (iss1_q.size() == 0) check("dut1 unexpected issue (cycle)", rel, -1);
        else begin
          ie = iss1_q.pop_front();
          check("dut1 issue cycle", rel, ie.cyc);
          check("dut1 win_row", int'(bus1.win_row), ie.row);
          check("dut1 win_col", int'(bus1.win_col), ie.col);
        end
      end
      if (bus1.wr_en) begin
        if (wr1_q.size() == 0) check("dut1 unexpected wr_en (cycle)", rel, -1);
        else begin
          we = wr1_q.pop_front();
          check("dut1 wr cycle", rel, we.cyc);
          check("dut1 wr_addr", int'(bus1.wr_addr), we.addr);
        end
      end
      if (bus1.done) begin
        if (done1_q.size() == 0) check("dut1 unexpected done (cycle)", rel, -1);
        else begin
          de = done1_q.pop_front();
          check("dut1 done cycle", rel, de);
          check("dut1 busy low at done", int'(bus1.busy), 0);
        end
      end
      if (bus2.pool_valid) begin
        if (iss2_q.size() == 0) check("dut2 unexpected issue (cycle)", rel, -1);
        else begin
          ie = iss2_q.pop_front();
          check("dut2 issue cycle", rel, ie.cyc);
          check("dut2 win_row", int'(bus2.win_row), ie.row);
          check("dut2 win_col", int'(bus2.win_col), ie.col);
        end
      end
      if (bus2.wr_en) begin
        if (wr2_q.size() == 0) check("dut2 unexpected wr_en (cycle)", rel, -1);
        else begin
          we = wr2_q.pop_front();
          check("dut2 wr cycle", rel, we.cyc);
          check("dut2 wr_addr", int'(bus2.wr_addr), we.addr);
        end
      end
      if (bus2.done) begin
        if (done2_q.size() == 0) check("dut2 unexpected done (cycle)", rel, -1);
        else begin
          de = done2_q.pop_front();
          check("dut2 done cycle", rel, de);
        end
      end
    end
  end

  task automatic check_reset1(input string tag);
    check({tag, " pool_valid"}, int'(bus1.pool_valid), 0);
    check({tag, " win_row"}, int'(bus1.win_row), 0);
    check({tag, " win_col"}, int'(bus1.win_col), 0);
    check({tag, " wr_en"}, int'(bus1.wr_en), 0);
    check({tag, " wr_addr"}, int'(bus1.wr_addr), 0);
    check({tag, " busy"}, int'(bus1.busy), 0);
    check({tag, " done"}, int'(bus1.done), 0);
    check({tag, " err"}, int'(bus1.err), 0);
  endtask

  task automatic check_drained1(input string tag);
    check({tag, " issue queue left"}, iss1_q.size(), 0);
    check({tag, " write queue left"}, wr1_q.size(), 0);
    check({tag, " done queue left"}, done1_q.size(), 0);
  endtask

  // 8x8 pass on dut1; stall drops out_ready in cycles 5-7, abort_at asserts reset mid-pass.
  task automatic run_pass(input bit stall, input bit repulse, input int abort_at);
    int ic;
    bit seen;
    for (int k = 0; k < 16; k++) begin
      ic = 1 + k + ((stall && k >= 4) ? 3 : 0);
      if (abort_at == 0 || ic < abort_at) iss1_q.push_back('{ic, 2 * (k / 4), 2 * (k % 4)});
      if (abort_at == 0 || ic + 2 < abort_at) wr1_q.push_back('{ic + 2, k});
    end
    if (abort_at == 0) done1_q.push_back(stall ? 22 : 19);

    @(negedge clk) bus1.start = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    bus1.start = 1'b0;
    seen = 1'b0;
    for (int rel = 1; rel <= 40; rel++) begin
      bus1.out_ready = !(stall && rel >= 5 && rel <= 7);
      bus1.start     = repulse && (rel == 4 || rel == 12);
      if (rel == 1) begin
        check("busy after start", int'(bus1.busy), 1);
        check("err cleared by start", int'(bus1.err), 0);
      end
      if (rel == abort_at) begin
        rst_n = 1'b0;
        #1 check_reset1("async reset");
        break;
      end
      @(negedge clk);
      if (bus1.done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    bus1.start     = 1'b0;
    bus1.out_ready = 1'b1;
    if (abort_at != 0) begin
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check_drained1("aborted pass");
    end else begin
      check("done seen within budget", int'(seen), 1);
    end
    repeat (4) @(posedge clk);
    #1 check_drained1("pass end");
    check("err after pass", int'(bus1.err), 0);
    check("busy idle after pass", int'(bus1.busy), 0);
  endtask

  task automatic run_small;
    bit seen;
    iss2_q.push_back('{1, 0, 0});
    wr2_q.push_back('{2, 0});
    done2_q.push_back(3);
    @(negedge clk) bus2.start = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    bus2.start = 1'b0;
    seen = 1'b0;
    for (int rel = 1; rel <= 10; rel++) begin
      @(negedge clk);
      if (bus2.done) begin
        seen = 1'b1;
        break;
      end
    end
    check("dut2 done seen within budget", int'(seen), 1);
    repeat (3) @(posedge clk);
    #1 check("dut2 issue queue left", iss2_q.size(), 0);
    check("dut2 write queue left", wr2_q.size(), 0);
    check("dut2 done queue left", done2_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus1.start     = 1'b0;
    bus1.out_ready = 1'b1;
    bus2.start     = 1'b0;
    bus2.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset1("reset");
    check("dut2 reset busy", int'(bus2.busy), 0);
    check("dut2 reset pool_valid", int'(bus2.pool_valid), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_pass(1'b0, 1'b0, 0);
    run_pass(1'b1, 1'b0, 0);

    // Stray return while idle: flagged, not written, sticky.
    @(posedge clk);
    #1 inject = 1'b1;
    @(negedge clk) check("stray no wr_en", int'(bus1.wr_en), 0);
    @(posedge clk);
    #1 inject = 1'b0;
    check("err set by stray", int'(bus1.err), 1);
    repeat (3) @(posedge clk);
    #1 check("err sticky", int'(bus1.err), 1);
    check("wr_addr unmoved by stray", int'(bus1.wr_addr), 0);

    run_pass(1'b0, 1'b1, 0);
    run_pass(1'b0, 1'b0, 10);
    run_pass(1'b0, 1'b0, 0);
    run_small();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
